// File: rtl/booth_digit_encoder.sv
// -----------------------------------------------------------------------------
// booth_digit_encoder
//
// Radix-4 Booth recoder. Takes an unsigned multiplier operand and streams one
// 3-bit signed-digit code per cycle, least-significant digit first, to the
// per-row partial-product decoders. The operand is zero-extended by two bits,
// so an operand of WIDTH bits produces NDIG = WIDTH/2+1 digits, and the
// digits always sum (weighted by 4^k) to the operand exactly.
//
// Digit code {two, one, neg}:
//   0 -> 000   +1 -> 010   +2 -> 100   -1 -> 011   -2 -> 101
//   Zero is always 000; a negative zero is never produced.
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous, active-high reset
//   in_valid   in   1      operand offered
//   in_ready   out  1      encoder idle and able to take an operand
//   in_x       in   WIDTH  unsigned multiplier operand
//   out_valid  out  1      out_sdn/out_idx/out_last valid
//   out_ready  in   1      consumer accepts the current digit
//   out_sdn    out  3      {two, one, neg} digit code
//   out_idx    out  IDXW   digit index k (weight 4^k)
//   out_last   out  1      high on digit NDIG-1
//
// WIDTH must be even and at least 4.
// -----------------------------------------------------------------------------
module booth_digit_encoder #(
    parameter  int WIDTH = 8,
    localparam int NDIG  = WIDTH / 2 + 1,
    localparam int IDXW  = $clog2(NDIG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_sdn,
    output logic [IDXW-1:0]  out_idx,
    output logic             out_last
);

    typedef enum logic {
        S_IDLE,
        S_ENCODE
    } state_t;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NDIG - 1);

    // Booth triplet {xe[2k+1], xe[2k], xe[2k-1]} for digit k. The operand is
    // framed as {2'b00, x, 1'b0} so that xe[-1] is bit 0 of the frame and a
    // right shift by 2k lines the triplet up at bits [2:0].
    function automatic logic [2:0] booth_code(input logic [WIDTH-1:0] x,
                                              input logic [IDXW-1:0]  k);
        logic [WIDTH+2:0] xe;
        logic [2:0]       t;
        xe = {2'b00, x, 1'b0};
        t  = 3'(xe >> {k, 1'b0});
        case (t)
            3'b001, 3'b010: booth_code = 3'b010;  // +1
            3'b011:         booth_code = 3'b100;  // +2
            3'b100:         booth_code = 3'b101;  // -2
            3'b101, 3'b110: booth_code = 3'b011;  // -1
            default:        booth_code = 3'b000;  // 000 and 111 are zero
        endcase
    endfunction

    state_t           r_state;
    logic [WIDTH-1:0] r_x;
    logic [IDXW-1:0]  r_idx;
    logic [2:0]       r_sdn;
    logic             r_valid;
    logic             r_in_ready;
    logic             r_last;

    logic [IDXW-1:0]  w_next_idx;
    logic [2:0]       w_sdn_first;
    logic [2:0]       w_sdn_next;

    // Next digit codes are computed ahead and captured into r_sdn, so the
    // outputs come straight from flops with no combinational path from in_x.
    assign w_next_idx  = r_idx + IDXW'(1);
    assign w_sdn_first = booth_code(in_x, '0);
    assign w_sdn_next  = booth_code(r_x, w_next_idx);

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values, independent of statement order inside the block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_x        <= '0;
            r_idx      <= '0;
            r_sdn      <= 3'b000;
            r_valid    <= 1'b0;
            r_in_ready <= 1'b1;
            r_last     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_x        <= in_x;
                        r_idx      <= '0;
                        r_sdn      <= w_sdn_first;
                        r_last     <= 1'b0;
                        r_valid    <= 1'b1;
                        r_in_ready <= 1'b0;
                        r_state    <= S_ENCODE;
                    end
                end
                S_ENCODE: begin
                    // Without out_ready every output register keeps its value,
                    // which is what holds the digit stable under backpressure.
                    if (r_valid && out_ready) begin
                        if (r_last) begin
                            r_valid    <= 1'b0;
                            r_in_ready <= 1'b1;
                            r_last     <= 1'b0;
                            r_state    <= S_IDLE;
                        end else begin
                            r_idx  <= w_next_idx;
                            r_sdn  <= w_sdn_next;
                            r_last <= (w_next_idx == LAST_IDX);
                        end
                    end
                end
                default: begin
                    r_valid    <= 1'b0;
                    r_in_ready <= 1'b1;
                    r_last     <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_valid;
    assign out_sdn   = r_sdn;
    assign out_idx   = r_idx;
    assign out_last  = r_last;

endmodule

// File: tb/tb_booth_digit_encoder.sv
// -----------------------------------------------------------------------------
// tb_booth_digit_encoder
//
// Bench for booth_digit_encoder (WIDTH=8, five digits per operand). Inputs
// are driven and outputs sampled on the falling clock edge. Expected digits
// come from a fixed vector table and from an arithmetic Booth model that
// derives each signed digit as x[2k-1] + x[2k] - 2*x[2k+1].
// -----------------------------------------------------------------------------
module tb_booth_digit_encoder;

    localparam int WIDTH = 8;
    localparam int NDIG  = WIDTH / 2 + 1;
    localparam int IDXW  = $clog2(NDIG);

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_x;
    logic             out_valid;
    logic             out_ready;
    logic [2:0]       out_sdn;
    logic [IDXW-1:0]  out_idx;
    logic             out_last;

    int errors = 0;
    int checks = 0;

    booth_digit_encoder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sdn   (out_sdn),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0]     x;
        logic [NDIG-1:0][2:0] sdn;  // index k holds digit k
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Signed Booth digit k of x, from the bit-weight identity.
    function automatic int model_digit(input int x, input int k);
        int lo;
        int mid;
        int hi;
        lo  = (k == 0) ? 0 : ((x >> (2 * k - 1)) & 1);
        mid = (x >> (2 * k)) & 1;
        hi  = (x >> (2 * k + 1)) & 1;
        return lo + mid - 2 * hi;
    endfunction

    function automatic logic [2:0] model_code(input int d);
        case (d)
            0:       return 3'b000;
            1:       return 3'b010;
            2:       return 3'b100;
            -1:      return 3'b011;
            -2:      return 3'b101;
            default: return 3'b111;
        endcase
    endfunction

    // Decoder side: signed multiple of y selected by a digit code.
    function automatic longint decode_pp(input logic [2:0] s, input longint y);
        longint mag;
        mag = s[2] ? 2 * y : (s[1] ? y : 0);
        return s[0] ? -mag : mag;
    endfunction

    // Offers one operand from IDLE with out_ready high, then checks every digit
    // against the table and the return to IDLE.
    task automatic run_vec(input vec_t v, input string tag);
        check({tag, " in_ready before op"}, in_ready, 1);
        in_x      = v.x;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < NDIG; k++) begin
            check({tag, " out_valid"}, out_valid, 1);
            check({tag, " out_idx"}, out_idx, k);
            check({tag, " out_sdn"}, out_sdn, v.sdn[k]);
            check({tag, " out_last"}, out_last, (k == NDIG - 1));
            @(negedge clk);
        end
        check({tag, " out_valid after last"}, out_valid, 0);
        check({tag, " in_ready after last"}, in_ready, 1);
    endtask

    initial begin
        longint acc;
        longint dsum;
        longint y;
        int     x;
        int     cnt;
        int     cyc;
        bit     done;
        bit     rdy;

        vecs[0] = '{x: 8'h0B, sdn: {3'b000, 3'b000, 3'b010, 3'b011, 3'b011}};
        vecs[1] = '{x: 8'hFF, sdn: {3'b010, 3'b000, 3'b000, 3'b000, 3'b011}};
        vecs[2] = '{x: 8'h06, sdn: {3'b000, 3'b000, 3'b000, 3'b100, 3'b101}};
        vecs[3] = '{x: 8'h00, sdn: {3'b000, 3'b000, 3'b000, 3'b000, 3'b000}};
        vecs[4] = '{x: 8'hAA, sdn: {3'b010, 3'b011, 3'b011, 3'b011, 3'b101}};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_x      = '0;
        out_ready = 1'b0;
        #2;
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset out_sdn", out_sdn, 0);
        check("reset out_idx", out_idx, 0);
        check("reset out_last", out_last, 0);
        #10 rst = 1'b0;
        @(negedge clk);

        // Fixed vectors, back to back.
        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Backpressure on digit 1 while a new operand is offered.
        in_x      = 8'h0B;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("bp digit0 idx", out_idx, 0);
        @(negedge clk);
        out_ready = 1'b0;
        in_x      = 8'h55;
        in_valid  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            check("bp held idx", out_idx, 1);
            check("bp held sdn", out_sdn, 3'b011);
            check("bp held valid", out_valid, 1);
            check("bp in_ready low", in_ready, 0);
            @(negedge clk);
        end
        check("bp after stall idx", out_idx, 1);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int k = 1; k < NDIG; k++) begin
            check("bp resume idx", out_idx, k);
            check("bp resume sdn", out_sdn, vecs[0].sdn[k]);
            @(negedge clk);
        end
        check("bp end out_valid", out_valid, 0);
        check("bp end in_ready", in_ready, 1);

        // Reset mid-stream at digit 2, then a clean operand.
        in_x      = 8'hAA;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst mid idx before", out_idx, 2);
        #1 rst = 1'b1;
        #1;
        check("rst mid out_valid", out_valid, 0);
        check("rst mid in_ready", in_ready, 1);
        check("rst mid out_idx", out_idx, 0);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst no resume", out_valid, 0);
        run_vec(vecs[2], "post-rst");

        // Random operands with random backpressure, checked through a decoder.
        for (int op = 0; op < 1000; op++) begin
            x = int'($urandom_range(0, 255));
            y = longint'($urandom_range(0, 65535));
            check("rnd in_ready", in_ready, 1);
            in_x      = WIDTH'(x);
            in_valid  = 1'b1;
            out_ready = 1'b0;
            @(negedge clk);
            in_valid = 1'b0;
            cnt  = 0;
            cyc  = 0;
            acc  = 0;
            dsum = 0;
            done = 1'b0;
            while (!done && cyc < 100) begin
                if (out_valid) begin
                    check("rnd idx", out_idx, cnt);
                    check("rnd sdn", out_sdn, model_code(model_digit(x, cnt)));
                    check("rnd last", out_last, (cnt == NDIG - 1));
                    rdy       = ($urandom_range(0, 9) < 7);
                    out_ready = rdy;
                    if (rdy) begin
                        acc  += decode_pp(out_sdn, y) <<< (2 * cnt);
                        dsum += decode_pp(out_sdn, 1) <<< (2 * cnt);
                        if (cnt == NDIG - 1) done = 1'b1;
                        cnt++;
                    end
                end else begin
                    out_ready = 1'b0;
                end
                @(negedge clk);
                cyc++;
            end
            out_ready = 1'b0;
            check("rnd stream complete", done, 1);
            check("rnd product", acc, y * x);
            check("rnd digit sum", dsum, x);
            check("rnd idle after op", out_valid, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
